// File: rtl/enigma_uart_tx.sv
// enigma_uart_tx: output stage behind the Enigma cipher core.
// Maps letter indices 0..25 to ASCII 'A'..'Z' (anything else becomes '?'),
// buffers the characters in a small FIFO and sends them as 8N1 UART frames.
// Optional feature macro: GROUP5_EN inserts a space frame after every
// group of five letters, but only when another letter is already waiting.
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   in_valid  cipher core presents a letter this cycle
//   in_letter letter index, 0 = 'A'
//   in_ready  FIFO can accept (registered, equals !full)
//   tx        UART line, idle high
//   busy      frame in flight or FIFO non-empty
//   drop_err  sticky, set when a letter arrives while in_ready is low
module enigma_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned LETTER_W     = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [LETTER_W-1:0] in_letter,
  output logic                in_ready,
  output logic                tx,
  output logic                busy,
  output logic                drop_err
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic              tx_q, tx_d, busy_q, busy_d;
  logic              in_ready_q, in_ready_d, drop_q, drop_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
`ifdef GROUP5_EN
  logic [2:0]        group_q, group_d;
`endif

  logic       empty, full_d, wr_en, baud_done, space_ins;
  logic [7:0] char_c;

  assign empty     = (wptr_q == rptr_q);
  assign wr_en     = in_valid && in_ready_q;
  assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign char_c    = (32'(in_letter) < 32'd26) ? (8'h41 + 8'(in_letter)) : 8'h3F;
`ifdef GROUP5_EN
  assign space_ins = (group_q == 3'd5);
`else
  assign space_ins = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!empty)                         state_d = START;
      START: if (baud_done)                      state_d = DATA;
      DATA:  if (baud_done && (bit_q == 3'd7))   state_d = STOP;
      STOP:  if (baud_done)                      state_d = IDLE;
    endcase
  end

  // Datapath next values: FIFO pointers, baud/bit counters, shift register
  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
`ifdef GROUP5_EN
    group_d = group_q;
`endif
    if (wr_en) wptr_d = wptr_q + PW'(1);
    if (state_q == IDLE) begin
      baud_d = '0;
      bit_d  = '0;
      if (!empty) begin
        if (space_ins) begin
          // Space frame leaves the FIFO head in place for the next frame
          shift_d = 8'h20;
`ifdef GROUP5_EN
          group_d = 3'd0;
`endif
        end else begin
          shift_d = mem_q[rptr_q[AW-1:0]];
          rptr_d  = rptr_q + PW'(1);
`ifdef GROUP5_EN
          group_d = group_q + 3'd1;
`endif
        end
      end
    end else if (baud_done) begin
      baud_d = '0;
      if (state_q == DATA) begin
        shift_d = {1'b0, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
      end
    end else begin
      baud_d = baud_q + BAUD_W'(1);
    end
  end

  // Output logic; tx and busy lag the state by one cycle, in_ready tracks next occupancy
  always_comb begin
    tx_d = 1'b1;
    if (state_q == START)     tx_d = 1'b0;
    else if (state_q == DATA) tx_d = shift_q[0];
    busy_d     = (state_q != IDLE) || !empty;
    full_d     = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    in_ready_d = !full_d;
    drop_d     = drop_q || (in_valid && !in_ready_q);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
      drop_q     <= 1'b0;
`ifdef GROUP5_EN
      group_q    <= '0;
`endif
    end else begin
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      drop_q     <= drop_d;
`ifdef GROUP5_EN
      group_q    <= group_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= char_c;
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign in_ready = in_ready_q;
  assign drop_err = drop_q;

endmodule

// File: tb/tb_enigma_uart_tx.sv
module tb_enigma_uart_tx;
  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int LW       = 5;
  localparam int SLOW_CPB = 434;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_ready, tx, busy, drop_err;
  logic [LW-1:0] in_letter;
  logic          s_valid, s_ready, s_tx, s_busy, s_drop;
  logic [LW-1:0] s_letter;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q [$];

  enigma_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .LETTER_W(LW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_letter(in_letter),
    .in_ready(in_ready), .tx(tx), .busy(busy), .drop_err(drop_err));

  enigma_uart_tx #(.CLKS_PER_BIT(SLOW_CPB), .FIFO_DEPTH(DEPTH), .LETTER_W(LW)) u_slow (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_letter(s_letter),
    .in_ready(s_ready), .tx(s_tx), .busy(s_busy), .drop_err(s_drop));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input int l);
    in_letter = LW'(l);
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_drain"}, 32'(n < 3000), 32'd1);
  endtask

  // Monitor: decode UART frames from tx, abandoning any frame cut by reset
  initial begin : monitor
    bit         active = 1'b0;
    int         cnt = 0;
    logic [7:0] b = '0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1;
          cnt    = 0;
        end
      end else begin
        cnt++;
        if (cnt >= CPB + CPB/2 && cnt <= 8*CPB + CPB/2 && ((cnt - CPB/2) % CPB) == 0)
          b[(cnt - CPB/2)/CPB - 1] = tx;
        if (cnt == 9*CPB + CPB/2) begin
          check("stop_bit", 32'(tx), 32'd1);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: got 0x%02h expected no frame", b);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", 32'(b), 32'(e));
          end
          active = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [6:0] rdy_exp = 7'b0011111;
    string      exp_s;
    int         lows, n, width;
    rst_n = 1'b0; in_valid = 1'b0; in_letter = '0;
    s_valid = 1'b0; s_letter = '0;
    tick(); tick();
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_drop_err", 32'(drop_err), 32'd0);
    rst_n = 1'b1;

    // Letter 0: latency and frame length
    exp_q.push_back(8'h41);
    send(0);
    check("lat_n0_tx", 32'(tx), 32'd1);
    tick();
    check("lat_n1_tx", 32'(tx), 32'd1);
    tick();
    check("lat_n2_tx", 32'(tx), 32'd0);
    repeat (39) tick();
    check("busy_n41", 32'(busy), 32'd1);
    tick();
    check("busy_n42", 32'(busy), 32'd0);
    check("frame1_done", 32'(exp_q.size()), 32'd0);

    // Letters 25 and 26
    do_reset();
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h3F);
    send(25);
    send(26);
    wait_idle("t2");
    check("t2_drop_err", 32'(drop_err), 32'd0);

    // Seven consecutive letters into a 4-deep FIFO
    do_reset();
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t3_in_ready_%0d", i), 32'(in_ready), 32'(rdy_exp[i]));
      if (i < 5) exp_q.push_back(8'h42 + 8'(i));
      in_letter = LW'(i + 1);
      in_valid  = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("t3_drop_set", 32'(drop_err), 32'd1);
    wait_idle("t3");
    check("t3_drop_sticky", 32'(drop_err), 32'd1);
    do_reset();
    check("t3_drop_cleared", 32'(drop_err), 32'd0);

    // Reset during data bit 3
    send(2);
    repeat (19) tick();
    rst_n = 1'b0;
    tick();
    check("t4_tx", 32'(tx), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    lows = 0;
    repeat (100) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    check("t4_no_frame", 32'(lows), 32'd0);
    exp_q.push_back(8'h44);
    send(3);
    wait_idle("t4");

    // Letters 0..6 spaced out so the FIFO never fills
    do_reset();
`ifdef GROUP5_EN
    exp_s = "ABCDE FG";
`else
    exp_s = "ABCDEFG";
`endif
    for (int j = 0; j < exp_s.len(); j++) exp_q.push_back(8'(exp_s[j]));
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t5_in_ready_%0d", i), 32'(in_ready), 32'd1);
      send(i);
      repeat (44) tick();
    end
    wait_idle("t5");

    // Start-bit width at the full baud divisor
    check("slow_ready", 32'(s_ready), 32'd1);
    s_letter = '0;
    s_valid  = 1'b1;
    tick();
    s_valid = 1'b0;
    n = 0;
    while (s_tx !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    check("slow_start_seen", 32'(n < 10), 32'd1);
    width = 0;
    while (s_tx === 1'b0 && width < 1000) begin
      tick();
      width++;
    end
    check("slow_start_width", 32'(width), 32'(SLOW_CPB));
    check("slow_busy", 32'(s_busy), 32'd1);
    check("slow_drop_err", 32'(s_drop), 32'd0);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
